// File: rtl/adc_spi_capture.sv
// adc_spi_capture: periodic 16-clock serial read of an AD7476-class 12-bit ADC.
// Each frame is 4 leading zeros followed by 12 data bits, MSB first. The
// captured sample is presented on ADC_o with a one-cycle dataf_o strobe.
// Frames with a nonzero leading bit raise fmt_err_o. Conversion requests that
// arrive while a frame is in progress are dropped and latch ovr_o.
module adc_spi_capture #(
  parameter int CLK_DIV       = 4,     // clk_i cycles per SCLK half-period (>= 2)
  parameter int SAMPLE_PERIOD = 1000   // clk_i cycles between conversion starts
) (
  input  logic        clk_i,
  input  logic        reset,          // asynchronous, active low
  input  logic        en_i,
  input  logic        adc_sdata_i,
  output logic        adc_cs_n_o,
  output logic        adc_sclk_o,
  output logic [11:0] ADC_o,
  output logic        dataf_o,
  output logic        fmt_err_o,
  output logic        ovr_o,
  output logic        busy_o
);

  localparam int CW = $clog2(SAMPLE_PERIOD + 1);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    DONE     = 3'd3,
    QUIET    = 3'd4
  } state_t;

  // Sample timer
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          tick;

  // FSM and datapath state
  state_t        state_reg, state_next;
  logic [DW-1:0] div_reg, div_next;       // cycles spent in current phase
  logic [3:0]    bit_reg, bit_next;       // bit index within the frame
  logic          phase_reg, phase_next;   // 0 = sclk low half, 1 = sclk high half
  logic [15:0]   shift_reg, shift_next;

  // Registered outputs
  logic          cs_n_reg, cs_n_next;
  logic          sclk_reg, sclk_next;
  logic [11:0]   adc_reg, adc_next;
  logic          dataf_reg, dataf_next;
  logic          fmt_reg, fmt_next;
  logic          ovr_reg, ovr_next;
  logic          busy_reg, busy_next;

  // The counter rests at its terminal value while disabled, so the very first
  // cycle that sees en_i high already produces a tick.
  assign tick = en_i && (cnt_reg == CNT_LAST);

  // Next value of the sample timer
  always_comb begin
    cnt_next = cnt_reg;
    if (!en_i) begin
      cnt_next = CNT_LAST;
    end else if (tick) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Sample timer register
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      cnt_reg <= CNT_LAST;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being
  // entered so that every port comes straight from a flop.
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    phase_next = phase_reg;
    shift_next = shift_reg;
    cs_n_next  = cs_n_reg;
    sclk_next  = sclk_reg;
    adc_next   = adc_reg;
    dataf_next = 1'b0;
    fmt_next   = fmt_reg;
    // A tick that cannot start a frame is lost, not queued.
    ovr_next   = ovr_reg | (tick && (state_reg != IDLE));

    case (state_reg)
      IDLE: begin
        if (tick) begin
          state_next = CS_SETUP;
          div_next   = '0;
          cs_n_next  = 1'b0;
          sclk_next  = 1'b1;
        end
      end

      CS_SETUP: begin
        if (div_reg == DIV_LAST) begin
          state_next = SHIFT;
          div_next   = '0;
          bit_next   = '0;
          phase_next = 1'b0;
          sclk_next  = 1'b0;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end

      SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (!phase_reg) begin
            // Last low cycle: the ADC has had a full half-period to settle.
            shift_next = {shift_reg[14:0], adc_sdata_i};
            phase_next = 1'b1;
            sclk_next  = 1'b1;
          end else if (bit_reg == 4'd15) begin
            // Frame complete: publish the sample as DONE is entered.
            state_next = DONE;
            cs_n_next  = 1'b1;
            sclk_next  = 1'b1;
            dataf_next = 1'b1;
            adc_next   = shift_reg[11:0];
            fmt_next   = |shift_reg[15:12];
          end else begin
            bit_next   = bit_reg + 1'b1;
            phase_next = 1'b0;
            sclk_next  = 1'b0;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end

      DONE: begin
        state_next = QUIET;
        div_next   = '0;
      end

      QUIET: begin
        if (div_reg == DIV_LAST) begin
          state_next = IDLE;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cs_n_next  = 1'b1;
        sclk_next  = 1'b1;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // FSM, shift register and output registers
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
      phase_reg <= 1'b0;
      shift_reg <= '0;
      cs_n_reg  <= 1'b1;
      sclk_reg  <= 1'b1;
      adc_reg   <= '0;
      dataf_reg <= 1'b0;
      fmt_reg   <= 1'b0;
      ovr_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      phase_reg <= phase_next;
      shift_reg <= shift_next;
      cs_n_reg  <= cs_n_next;
      sclk_reg  <= sclk_next;
      adc_reg   <= adc_next;
      dataf_reg <= dataf_next;
      fmt_reg   <= fmt_next;
      ovr_reg   <= ovr_next;
      busy_reg  <= busy_next;
    end
  end

  assign adc_cs_n_o = cs_n_reg;
  assign adc_sclk_o = sclk_reg;
  assign ADC_o      = adc_reg;
  assign dataf_o    = dataf_reg;
  assign fmt_err_o  = fmt_reg;
  assign ovr_o      = ovr_reg;
  assign busy_o     = busy_reg;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: a default instance (SAMPLE_PERIOD=1000) driven by
// a table of frames plus en_i-drop and mid-frame reset sequences, and a second
// instance with SAMPLE_PERIOD=100 for the overrun behaviour.
module tb_adc_spi_capture;

  localparam int CD    = 4;
  localparam int SP_A  = 1000;
  localparam int SP_B  = 100;
  localparam int LAT   = 33 * CD + 1;   // tick cycle to strobe cycle

  logic clk;
  int   cyc;
  int   total;
  int   bad;

  // Instance A
  logic        rst_a, en_a, sdata_a;
  logic        cs_n_a, sclk_a, dataf_a, fmt_a, ovr_a, busy_a;
  logic [11:0] adc_a;
  // Instance B
  logic        rst_b, en_b, sdata_b;
  logic        cs_n_b, sclk_b, dataf_b, fmt_b, ovr_b, busy_b;
  logic [11:0] adc_b;

  adc_spi_capture #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_A)) dut_a (
    .clk_i(clk), .reset(rst_a), .en_i(en_a), .adc_sdata_i(sdata_a),
    .adc_cs_n_o(cs_n_a), .adc_sclk_o(sclk_a), .ADC_o(adc_a),
    .dataf_o(dataf_a), .fmt_err_o(fmt_a), .ovr_o(ovr_a), .busy_o(busy_a)
  );

  adc_spi_capture #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_B)) dut_b (
    .clk_i(clk), .reset(rst_b), .en_i(en_b), .adc_sdata_i(sdata_b),
    .adc_cs_n_o(cs_n_b), .adc_sclk_o(sclk_b), .ADC_o(adc_b),
    .dataf_o(dataf_b), .fmt_err_o(fmt_b), .ovr_o(ovr_b), .busy_o(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ADC models: latch the word at CS fall, present one bit per SCLK fall, MSB first.
  logic [15:0] word_a, cur_a, word_b, cur_b;
  int          idx_a, idx_b;

  always @(negedge cs_n_a) begin idx_a = 15; cur_a = word_a; end
  always @(negedge sclk_a) if (!cs_n_a && idx_a >= 0) begin sdata_a = cur_a[idx_a]; idx_a = idx_a - 1; end
  always @(negedge cs_n_b) begin idx_b = 15; cur_b = word_b; end
  always @(negedge sclk_b) if (!cs_n_b && idx_b >= 0) begin sdata_b = cur_b[idx_b]; idx_b = idx_b - 1; end

  // Monitor for instance A, sampled on the falling clock edge.
  int   rises_a, falls_a, strobes_a, double_a, stray_a;
  logic prev_cs_a, prev_sclk_a, prev_dataf_a, prev_rst_a;
  logic [11:0] prev_adc_a;

  always @(negedge clk) begin
    if (!cs_n_a && prev_cs_a) begin
      rises_a = 0;
      falls_a = falls_a + 1;
    end
    if (sclk_a && !prev_sclk_a && !cs_n_a) rises_a = rises_a + 1;
    if (dataf_a) begin
      strobes_a = strobes_a + 1;
      if (prev_dataf_a) double_a = double_a + 1;
    end
    if (rst_a && prev_rst_a && (adc_a != prev_adc_a) && !dataf_a) stray_a = stray_a + 1;
    prev_cs_a    = cs_n_a;
    prev_sclk_a  = sclk_a;
    prev_dataf_a = dataf_a;
    prev_rst_a   = rst_a;
    prev_adc_a   = adc_a;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe_a(input int budget, output int t, output logic ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (dataf_a) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_rises_a(input int n, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rises_a >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [11:0] adc;
    logic        fmt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   t_en, t_prev, t_now, f0, s0, s1;
    logic ok;
    int   nst, nfall, k;
    int   t_st[4];
    int   t_fall[4];
    logic prev_cs, ovr_early, ovr_first;

    vecs[0] = '{16'h000A, 12'h00A, 1'b0};
    vecs[1] = '{16'h0FFF, 12'hFFF, 1'b0};
    vecs[2] = '{16'h0800, 12'h800, 1'b0};
    vecs[3] = '{16'h1123, 12'h123, 1'b1};
    vecs[4] = '{16'h0123, 12'h123, 1'b0};
    vecs[5] = '{16'h8000, 12'h000, 1'b1};
    vecs[6] = '{16'h0555, 12'h555, 1'b0};

    total = 0; bad = 0; cyc = 0;
    rises_a = 0; falls_a = 0; strobes_a = 0; double_a = 0; stray_a = 0;
    prev_cs_a = 1'b1; prev_sclk_a = 1'b1; prev_dataf_a = 1'b0; prev_rst_a = 1'b0; prev_adc_a = '0;
    rst_a = 1'b0; en_a = 1'b0; sdata_a = 1'b0; word_a = '0;
    rst_b = 1'b0; en_b = 1'b0; sdata_b = 1'b0; word_b = '0;
    idx_a = 15; idx_b = 15; cur_a = '0; cur_b = '0;

    // Reset state
    repeat (3) step();
    check("rst_cs_n", cs_n_a, 1);
    check("rst_sclk", sclk_a, 1);
    check("rst_adc", adc_a, 0);
    check("rst_flags", {dataf_a, fmt_a, ovr_a, busy_a}, 4'b0000);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) step();
    check("idle_disabled", {cs_n_a, busy_a}, 2'b10);

    // Table-driven frames at the default sample period
    word_a = vecs[0].word;
    en_a   = 1'b1;
    t_en   = cyc;
    step();
    check("cs_fall_after_tick", {cs_n_a, busy_a}, 2'b01);
    t_prev = 0;
    for (int i = 0; i < 7; i++) begin
      wait_strobe_a(SP_A + 300, t_now, ok);
      check($sformatf("v%0d_strobe_seen", i), ok, 1);
      if (i == 0) check("v0_latency", t_now - t_en, LAT);
      else        check($sformatf("v%0d_period", i), t_now - t_prev, SP_A);
      check($sformatf("v%0d_adc", i), adc_a, vecs[i].adc);
      check($sformatf("v%0d_fmt", i), fmt_a, vecs[i].fmt);
      check($sformatf("v%0d_sclk_rises", i), rises_a, 16);
      $display("frame %0d word=%04h adc=%03h fmt=%0b cycle=%0d", i, vecs[i].word, adc_a, fmt_a, t_now);
      t_prev = t_now;
      if (i < 6) word_a = vecs[i + 1].word;
    end
    check("no_ovr_default", ovr_a, 0);

    // Drop en_i in the middle of a frame
    word_a = 16'h0ABC;
    ok = 1'b0;
    for (int i = 0; i < SP_A + 100; i++) begin
      step();
      if (!cs_n_a) begin ok = 1'b1; break; end
    end
    check("endrop_cs_fall", ok, 1);
    wait_rises_a(5, 200, ok);
    check("endrop_bit5", ok, 1);
    repeat (CD + 1) step();
    en_a = 1'b0;
    f0 = falls_a;
    s0 = strobes_a;
    wait_strobe_a(300, t_now, ok);
    check("endrop_strobe_seen", ok, 1);
    check("endrop_adc", adc_a, 12'hABC);
    $display("frame en-drop word=0abc adc=%03h cycle=%0d", adc_a, t_now);
    repeat (3 * SP_A) step();
    check("endrop_no_cs", falls_a, f0);
    check("endrop_one_strobe", strobes_a, s0 + 1);
    check("endrop_idle", busy_a, 0);

    // Reset asserted in the middle of a frame
    word_a = 16'h0C3F;
    en_a   = 1'b1;
    step();
    check("rstmid_cs_fall", cs_n_a, 0);
    wait_rises_a(9, 200, ok);
    check("rstmid_bit9", ok, 1);
    repeat (3) step();
    s1 = strobes_a;
    rst_a = 1'b0;
    #1;
    check("rstmid_cs_n", cs_n_a, 1);
    check("rstmid_sclk", sclk_a, 1);
    check("rstmid_adc", adc_a, 0);
    check("rstmid_busy_dataf", {busy_a, dataf_a}, 2'b00);
    repeat (5) step();
    check("rstmid_no_strobe", strobes_a, s1);
    word_a = 16'h0765;
    t_en   = cyc;
    rst_a  = 1'b1;
    wait_strobe_a(300, t_now, ok);
    check("fresh_strobe_seen", ok, 1);
    check("fresh_latency", t_now - t_en, LAT);
    check("fresh_adc", adc_a, 12'h765);
    check("fresh_fmt", fmt_a, 0);
    check("fresh_sclk_rises", rises_a, 16);
    $display("frame post-reset word=0765 adc=%03h cycle=%0d", adc_a, t_now);
    en_a = 1'b0;
    repeat (3) step();
    check("single_cycle_strobes", double_a, 0);
    check("adc_held_between", stray_a, 0);

    // Overrun with a short sample period
    word_b  = 16'h0321;
    en_b    = 1'b1;
    k       = cyc;
    nst     = 0;
    nfall   = 0;
    prev_cs = 1'b1;
    ovr_early = 1'b1;
    ovr_first = 1'b0;
    for (int i = 0; i < 900; i++) begin
      step();
      if (!cs_n_b && prev_cs && nfall < 4) begin
        t_fall[nfall] = cyc;
        nfall = nfall + 1;
      end
      prev_cs = cs_n_b;
      if (cyc == k + SP_B / 2) ovr_early = ovr_b;
      if (dataf_b) begin
        if (nst == 0) ovr_first = ovr_b;
        t_st[nst] = cyc;
        nst = nst + 1;
        $display("frame short-period %0d adc=%03h ovr=%0b cycle=%0d", nst - 1, adc_b, ovr_b, cyc);
        if (nst == 4) break;
      end
    end
    check("ovr_strobes_seen", nst, 4);
    check("ovr_clear_early", ovr_early, 0);
    check("ovr_after_first", ovr_first, 1);
    if (nst == 4) begin
      check("ovr_first_latency", t_st[0] - k, LAT);
      for (int j = 0; j < 3; j++) begin
        check($sformatf("ovr_gap%0d", j), t_st[j + 1] - t_st[j], 2 * SP_B);
        check($sformatf("ovr_quiet%0d", j), t_fall[j + 1] - t_st[j], 2 * SP_B - 33 * CD);
      end
    end
    check("ovr_adc", adc_b, 12'h321);
    check("ovr_sticky", ovr_b, 1);
    en_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
